bcd_field_reg: RTL

Parametrised BCD field register for the RTC controller/interface datapath, one instance per time/date field (seconds, minutes, hours, day, month, year). It holds an NDIG-digit packed-BCD value and loads it from the RTC read path when the user is not editing. While editing, it steps the value up or down with range-aware wrap or saturation and auto-repeat on held buttons. It validates loads and flags user edits so the control FSM knows which fields to write back to the RTC.

---
 rtl/rtc_pkg.sv | 21 ++
 rtl/bcd_field_reg_if.sv | 23 ++
 rtl/bcd_step.sv | 54 +++++
 rtl/bcd_field_reg.sv | 100 ++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC datapath constants, BCD digit type and field ranges
package rtc_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] bcd_nib_t;

  localparam logic [7:0] SEG_MIN  = 8'h00;
  localparam logic [7:0] SEG_MAX  = 8'h59;
  localparam logic [7:0] MIN_MIN  = 8'h00;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HORA_MIN = 8'h00;
  localparam logic [7:0] HORA_MAX = 8'h23;
  localparam logic [7:0] DIA_MIN  = 8'h01;
  localparam logic [7:0] DIA_MAX  = 8'h31;
  localparam logic [7:0] MES_MIN  = 8'h01;
  localparam logic [7:0] MES_MAX  = 8'h12;
  localparam logic [7:0] ANO_MIN  = 8'h00;
  localparam logic [7:0] ANO_MAX  = 8'h99;

endpackage

// File: rtl/bcd_field_reg_if.sv
// rtl/bcd_field_reg_if.sv - button, load and value signals of one BCD field register
interface bcd_field_reg_if #(
  parameter int W = 8
);
  logic         UP;
  logic         DOWN;
  logic         Modificando;
  logic         Actualizar;
  logic [W-1:0] DATA_in;
  logic [W-1:0] DATA_out;
  logic         Cambio;
  logic         Err;

  modport master (
    output UP, DOWN, Modificando, Actualizar, DATA_in,
    input  DATA_out, Cambio, Err
  );

  modport slave (
    input  UP, DOWN, Modificando, Actualizar, DATA_in,
    output DATA_out, Cambio, Err
  );
endinterface

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - combinational NDIG-digit BCD +/-1 with range-aware wrap or saturation
module bcd_step
  import rtc_pkg::*;
#(
  parameter int                  NDIG    = 2,
  parameter logic [4*NDIG-1:0]   MIN_VAL = '0,
  parameter logic [4*NDIG-1:0]   MAX_VAL = '1,
  parameter bit                  WRAP    = 1'b1
) (
  input  logic [4*NDIG-1:0] val,
  input  logic              up,
  output logic [4*NDIG-1:0] nxt,
  output logic              at_lim
);
  localparam int W = NIB_W * NDIG;

  logic [W-1:0] arith;
  logic         cy;
  bcd_nib_t     nib;

  always_comb begin
    arith = '0;
    cy    = 1'b1;
    nib   = '0;
    // Carry/borrow ripples upward only while the lower digit rolled over.
    for (int i = 0; i < NDIG; i++) begin
      nib = val[i*NIB_W +: NIB_W];
      if (!cy) begin
        arith[i*NIB_W +: NIB_W] = nib;
      end else if (up) begin
        if (nib >= 4'd9) begin
          arith[i*NIB_W +: NIB_W] = 4'd0;
        end else begin
          arith[i*NIB_W +: NIB_W] = nib + 4'd1;
          cy = 1'b0;
        end
      end else begin
        if (nib == 4'd0) begin
          arith[i*NIB_W +: NIB_W] = 4'd9;
        end else begin
          arith[i*NIB_W +: NIB_W] = nib - 4'd1;
          cy = 1'b0;
        end
      end
    end

    at_lim = up ? (val >= MAX_VAL) : (val <= MIN_VAL);
    if (at_lim) begin
      nxt = WRAP ? (up ? MIN_VAL : MAX_VAL) : val;
    end else begin
      nxt = arith;
    end
  end
endmodule

// File: rtl/bcd_field_reg.sv
// rtl/bcd_field_reg.sv - BCD time/date field: RTC load with validation, button stepping, auto-repeat
module bcd_field_reg
  import rtc_pkg::*;
#(
  parameter int                NDIG     = 2,
  parameter logic [4*NDIG-1:0] MIN_VAL  = 8'h00,
  parameter logic [4*NDIG-1:0] MAX_VAL  = 8'h99,
  parameter logic [4*NDIG-1:0] RST_VAL  = 8'h22,
  parameter bit                WRAP     = 1'b1,
  parameter int                HOLD_CYC = 0,
  parameter int                REP_CYC  = 1
) (
  input logic             CLK,
  input logic             RST,
  bcd_field_reg_if.slave  bus
);
  localparam int W  = NIB_W * NDIG;
  localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYC - REP_CYC);

  logic          up_q, up_d, dn_q, dn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          cambio_q, cambio_d;
  logic          err_q, err_d;

  logic          single, press, held, rep_hit, step, load_ok;
  logic [W-1:0]  step_nxt;
  logic          step_at_lim;

  bcd_step #(
    .NDIG    (NDIG),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .WRAP    (WRAP)
  ) u_step (
    .val    (data_q),
    .up     (bus.UP),
    .nxt    (step_nxt),
    .at_lim (step_at_lim)
  );

  always_comb begin
    load_ok = (bus.DATA_in >= MIN_VAL) && (bus.DATA_in <= MAX_VAL);
    for (int i = 0; i < NDIG; i++) begin
      if (bus.DATA_in[i*NIB_W +: NIB_W] > 4'd9) load_ok = 1'b0;
    end
  end

  always_comb begin
    up_d     = bus.UP;
    dn_d     = bus.DOWN;
    single   = bus.UP ^ bus.DOWN;
    press    = bus.Modificando && single && ((bus.UP && !up_q) || (bus.DOWN && !dn_q));
    held     = bus.Modificando && single && ((bus.UP && up_q) || (bus.DOWN && dn_q));
    rep_hit  = (HOLD_CYC > 0) && held && ((int'(cnt_q) + 1) == HOLD_CYC);
    step     = press || rep_hit;

    // Any press, release, direction clash or leaving edit mode restarts the hold count.
    cnt_d = '0;
    if ((HOLD_CYC > 0) && held) begin
      cnt_d = rep_hit ? RELOAD : cnt_q + CW'(1);
    end

    data_d   = data_q;
    cambio_d = 1'b0;
    err_d    = 1'b0;
    if (bus.Modificando) begin
      if (step && !(step_at_lim && !WRAP)) begin
        data_d   = step_nxt;
        cambio_d = (step_nxt != data_q);
      end
    end else if (bus.Actualizar) begin
      if (load_ok) data_d = bus.DATA_in;
      else         err_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      cnt_q    <= '0;
      data_q   <= RST_VAL;
      cambio_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      up_q     <= up_d;
      dn_q     <= dn_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      cambio_q <= cambio_d;
      err_q    <= err_d;
    end
  end

  assign bus.DATA_out = data_q;
  assign bus.Cambio   = cambio_q;
  assign bus.Err      = err_q;
endmodule
